serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width in bits.
REQ-002 SHALL have port Clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port En, input, 1, start strobe; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH, minuend; captured on the accepted start.
REQ-006 SHALL have port B, input, WIDTH, subtrahend; captured on the accepted start.
REQ-007 SHALL have port Bin, input, 1, borrow-in; captured on the accepted start.
REQ-008 SHALL have port Diff, output, WIDTH, registered result A-B-Bin modulo 2^WIDTH.
REQ-009 SHALL have port Borrow, output, 1, registered final borrow-out, high when unsigned A < B+Bin.
REQ-010 SHALL have port Overflow, output, 1, registered two's-complement overflow flag.
REQ-011 SHALL have port Busy, output, 1, high while bits are being processed.
REQ-012 SHALL have port Done, output, 1, single-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE, on a rising edge with En=1: capture A, B and Bin; clear the bit counter; enter SHIFT.
REQ-015 SHALL, in SHIFT, process exactly one bit per cycle, LSB first, using a 1-bit full-subtractor and a registered borrow chain.
REQ-016 SHALL leave SHIFT for DONE on the edge that processes bit WIDTH-1; total time from capture edge to Done high is WIDTH cycles.
REQ-017 SHALL, on entering DONE, load Diff, Borrow and Overflow from the internal result together, and assert Done for exactly one cycle.
REQ-018 SHALL return from DONE to IDLE unconditionally on the next edge.
REQ-019 SHALL hold Diff, Borrow and Overflow stable from the DONE entry until the next DONE entry; they SHALL never show partial results.
REQ-020 SHALL compute Overflow = (A[MSB] != B[MSB]) AND (Diff[MSB] != A[MSB]) using the captured operands.
REQ-021 SHALL assert Busy in SHIFT only, and deassert it in IDLE and DONE.
REQ-022 SHALL ignore En while in SHIFT or DONE; operand changes after capture SHALL NOT affect the result.
REQ-023 SHALL accept a new start in the first IDLE cycle after DONE; minimum issue interval is WIDTH+2 cycles.
REQ-024 SHALL wrap the bit counter only through the DONE/IDLE path and never index beyond WIDTH-1.

Reset
REQ-025 SHALL, on Rst_n=0 at any time including mid-SHIFT, immediately force IDLE, clear the counter, the borrow chain and the operand registers, and set Diff=0, Borrow=0, Overflow=0, Busy=0 and Done=0.
REQ-026 SHALL abandon any in-flight operation on reset and emit no Done pulse for it.

Structure
REQ-027 SHALL place the WIDTH default and the state encoding (IDLE/SHIFT/DONE) in a shared package, adder_pkg.
REQ-028 SHALL use one sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), instantiated once.

Verification
REQ-029 SHALL cover: A=5, B=3, Bin=0, En pulse -> Diff=2, Borrow=0, Overflow=0, Done high exactly 4 cycles after the capture edge.
REQ-030 SHALL cover: A=3, B=5, Bin=0 -> Diff=14, Borrow=1, Overflow=0.
REQ-031 SHALL cover: A=8, B=1, Bin=0 -> Diff=7, Borrow=0, Overflow=1; and A=7, B=15 -> Diff=8, Borrow=1, Overflow=1.
REQ-032 SHALL cover: A=0, B=0, Bin=1 -> Diff=15, Borrow=1, Overflow=0.
REQ-033 SHALL cover: En held high and A/B toggled throughout an operation -> result matches the captured operands; the next start is taken on the first IDLE cycle after DONE.
REQ-034 SHALL cover: Rst_n low during the second SHIFT cycle -> all outputs 0 and no Done pulse; a following A=9, B=4 operation -> Diff=5, Borrow=0, Overflow=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the serial subtractor: default width, FSM
// state encoding and the two's-complement overflow rule.
package adder_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Overflow of a - b: operand signs differ and the result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures A, B, Bin on a start strobe, processes one
// bit per cycle LSB first through a single full subtractor, then publishes
// Diff/Borrow/Overflow together with a one-cycle Done pulse.
module serial_subtractor
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic             borrow_q;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             bout_bit;

    assign a_bit = a_q[cnt];
    assign b_bit = b_q[cnt];

    full_subtractor u_fs (
        .a    (a_bit),
        .b    (b_bit),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Partial result with the current bit merged in; on the last bit this is
    // the complete difference, so the outputs can load it on the same edge.
    always_comb begin
        res_next      = res_q;
        res_next[cnt] = d_bit;
    end

    // FSM, operand capture, borrow chain and registered result outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            Diff     <= '0;
            Borrow   <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (En) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        res_q    <= '0;
                        cnt      <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    res_q    <= res_next;
                    borrow_q <= bout_bit;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        Diff     <= res_next;
                        Borrow   <= bout_bit;
                        Overflow <= sub_overflow(a_q[WIDTH-1], b_q[WIDTH-1],
                                                 res_next[WIDTH-1]);
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = (state == ST_SHIFT);
    assign Done = (state == ST_DONE);

endmodule
